load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage directly downstream of the 32-bit ALU.
- Takes the ALU result as the effective address and issues one data-memory transaction per load/store over a req/gnt/rvalid bus.
- Formats store data and byte enables, and sign/zero-extends load data.
- Returns load results to writeback, raises alignment/encoding faults, and holds a busy flag that freezes upstream stages.

Parameters:
- XLEN, 32, data/address width; only 32 supported.
- RD_WIDTH, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX-stage instruction valid this cycle
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- funct3  in  3  RV32I load/store width/sign encoding
- addr  in  XLEN  effective address (ALU result)
- store_data  in  XLEN  rs2 value
- rd  in  RD_WIDTH  load destination register
- lsu_busy  out  1  transaction in flight; upstream must hold
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  response (load data or store ack)
- dmem_rdata  in  XLEN  load word
- wb_valid  out  1  load result valid (1-cycle pulse)
- wb_rd  out  RD_WIDTH  load destination
- wb_data  out  XLEN  extended load data
- lsu_fault  out  1  fault pulse (1 cycle)
- lsu_fault_cause  out  2  01 misaligned load, 10 misaligned store, 11 illegal encoding

Behaviour:
- Clock/reset: one clock clk; rst_n is asynchronous, active-low.
- Reset: all outputs 0; state IDLE; captured request registers 0.
- FSM: IDLE, REQ, WAIT. lsu_busy = (state != IDLE), driven from registered state only.
- IDLE, accept condition: ex_valid & (mem_read | mem_write) is sampled.
- IDLE, illegal encoding → next cycle lsu_fault=1, cause=11, no bus access, stay IDLE. Illegal means:
  - mem_read & mem_write both set;
  - a load with funct3 in {011,110,111};
  - a store with funct3 > 010.
- IDLE, misaligned → next cycle lsu_fault=1, cause 01/10, no bus access, stay IDLE. Misaligned means:
  - H/HU with addr[0]=1;
  - W with addr[1:0]!=0.
- IDLE, otherwise: capture funct3, addr[1:0], rd, we; register dmem_addr/be/wdata; go to REQ.
- ex_valid with neither mem_read nor mem_write: ignored.
- REQ: dmem_req=1 with stable addr/we/be/wdata. dmem_gnt=1 → WAIT (req drops next cycle). Otherwise hold indefinitely.
- WAIT: dmem_req=0. dmem_rvalid=1 → IDLE.
  - Load: wb_valid=1 next cycle with wb_rd and extended wb_data.
  - Store: ack only, no wb_valid.
- rvalid seen in REQ or IDLE: ignored (protocol violation, no state change).
- Minimum load latency (gnt in first REQ cycle, rvalid the following cycle): accept at cycle 0, REQ cycle 1, WAIT cycle 2, wb_valid cycle 3. lsu_busy is high in cycles 1–2.
- The upstream stage must present a new memory op only while lsu_busy=0. Inputs presented while busy are ignored.
- Store formatting:
  - SB: be = 0001<<addr[1:0], wdata = {4{store_data[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{store_data[15:0]}}.
  - SW: be = 1111, wdata = store_data.
  - Loads: be = 1111, wdata = 0.
- Load extraction: lane = dmem_rdata >> (8*addr[1:0]).
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: the word unchanged.
- wb_valid and lsu_fault are registered single-cycle pulses. wb_data/wb_rd hold their value until the next load completes.
- Reset mid-transaction: immediate return to IDLE, outputs cleared, the outstanding bus transaction is abandoned. The bus shares rst_n.

Decomposition:
- Shared package rv32i_pkg:
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW;
  - lsu_state_t enum {IDLE, REQ, WAIT};
  - lsu_fault_t enum {NONE=00, MIS_LD=01, MIS_ST=10, ILLEGAL=11}.
- One combinational sub-module lsu_align:
  - store path: funct3, addr[1:0], store_data → be, wdata, misaligned;
  - load path: funct3, addr[1:0], rdata → wb_data.
- The top module holds the FSM and registers.

Test Plan:
- LW at addr 0x100, gnt immediate, rvalid=0xDEADBEEF one cycle later → dmem_addr=0x100, be=1111; wb_valid in cycle 3, wb_data=0xDEADBEEF; lsu_busy high exactly 2 cycles.
- LB addr 0x103 with rdata 0x80FF_0000 → wb_data=0xFFFFFF80. LBU at the same address → 0x00000080. LH addr 0x102 → 0xFFFF80FF.
- SB addr 0x201 store_data 0x12345678 → be=0010, wdata=0x78787878, dmem_addr=0x200, dmem_we=1; ack completes with no wb_valid. SH addr 0x202 → be=1100, wdata=0x56785678.
- LW addr 0x102 → fault pulse cause=01, no dmem_req. SH addr 0x301 → cause=10. Load with funct3=011 → cause=11. mem_read&mem_write both set → cause=11.
- gnt withheld 5 cycles, then rvalid after 3 more → dmem_req held 5 cycles with stable outputs, busy throughout, one wb_valid; a second ex_valid load presented while busy is ignored.
- rst_n asserted during WAIT → all outputs 0 immediately. After release, a new SW proceeds normally and a late rvalid arriving in IDLE is ignored.

Source files
------------

// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I memory-stage encodings.
// funct3 widths, LSU FSM states and fault causes.
package rv32i_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        MIS_LD  = 2'b01,
        MIS_ST  = 2'b10,
        ILLEGAL = 2'b11
    } lsu_fault_t;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for the load/store unit.
// Store side builds byte enables and replicated data; load side extracts and extends.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  i_st_funct3,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_store_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ld_data
);

    logic        w_half;
    logic        w_word;
    logic [31:0] w_lane;

    // Load and store share the size encoding in funct3, so one check serves both
    assign w_half = (i_st_funct3 == LH) || (i_st_funct3 == LHU);
    assign w_word = (i_st_funct3 == LW);
    assign o_misaligned = (w_half && i_st_off[0])
                       || (w_word && (i_st_off != 2'b00));

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
        case (i_st_funct3)
            SB: begin
                o_be    = 4'b0001 << i_st_off;
                o_wdata = {4{i_store_data[7:0]}};
            end
            SH: begin
                o_be    = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_store_data;
            end
        endcase
    end

    assign w_lane = i_rdata >> {i_ld_off, 3'b000};

    always_comb begin
        o_ld_data = w_lane;
        case (i_ld_funct3)
            LB:      o_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
            LH:      o_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
            LBU:     o_ld_data = {24'd0, w_lane[7:0]};
            LHU:     o_ld_data = {16'd0, w_lane[15:0]};
            default: o_ld_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory stage issuing one req/gnt/rvalid transaction
// per load/store, with alignment/encoding fault pulses and a busy stall flag.
module load_store_unit
    import rv32i_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int RD_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    input  logic [XLEN-1:0]     addr,
    input  logic [XLEN-1:0]     store_data,
    input  logic [RD_WIDTH-1:0] rd,
    output logic                lsu_busy,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [3:0]          dmem_be,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                wb_valid,
    output logic [RD_WIDTH-1:0] wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                lsu_fault,
    output logic [1:0]          lsu_fault_cause
);

    lsu_state_t          r_state;
    logic [2:0]          r_funct3;
    logic [1:0]          r_off;
    logic [RD_WIDTH-1:0] r_rd;
    logic                r_we;
    logic [XLEN-1:0]     r_addr;
    logic [3:0]          r_be;
    logic [XLEN-1:0]     r_wdata;
    logic                r_wb_valid;
    logic [RD_WIDTH-1:0] r_wb_rd;
    logic [XLEN-1:0]     r_wb_data;
    logic                r_fault;
    lsu_fault_t          r_cause;

    logic                w_accept;
    logic                w_ld_bad;
    logic                w_st_bad;
    logic                w_illegal;
    logic                w_misaligned;
    logic [3:0]          w_be;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN-1:0]     w_ld_data;

    lsu_align u_align (
        .i_st_funct3  (funct3),
        .i_st_off     (addr[1:0]),
        .i_store_data (store_data),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_misaligned (w_misaligned),
        .i_ld_funct3  (r_funct3),
        .i_ld_off     (r_off),
        .i_rdata      (dmem_rdata),
        .o_ld_data    (w_ld_data)
    );

    assign w_accept  = (r_state == IDLE) && ex_valid && (mem_read || mem_write);
    assign w_ld_bad  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    assign w_st_bad  = (funct3 > SW);
    assign w_illegal = (mem_read && mem_write)
                    || (mem_read && w_ld_bad)
                    || (mem_write && w_st_bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_funct3   <= 3'b000;
            r_off      <= 2'b00;
            r_rd       <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= 4'b0000;
            r_wdata    <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_fault    <= 1'b0;
            r_cause    <= NONE;
        end else begin
            r_wb_valid <= 1'b0;
            r_fault    <= 1'b0;
            r_cause    <= NONE;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_fault <= 1'b1;
                            r_cause <= ILLEGAL;
                        end else if (w_misaligned) begin
                            r_fault <= 1'b1;
                            r_cause <= mem_read ? MIS_LD : MIS_ST;
                        end else begin
                            r_funct3 <= funct3;
                            r_off    <= addr[1:0];
                            r_rd     <= rd;
                            r_we     <= mem_write;
                            r_addr   <= {addr[XLEN-1:2], 2'b00};
                            r_be     <= mem_write ? w_be : 4'b1111;
                            r_wdata  <= mem_write ? w_wdata : '0;
                            r_state  <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // Stores complete on the ack alone; only loads write back
                    if (dmem_rvalid) begin
                        r_state <= IDLE;
                        if (!r_we) begin
                            r_wb_valid <= 1'b1;
                            r_wb_rd    <= r_rd;
                            r_wb_data  <= w_ld_data;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lsu_busy        = (r_state != IDLE);
    assign dmem_req        = (r_state == REQ);
    assign dmem_we         = r_we;
    assign dmem_addr       = r_addr;
    assign dmem_be         = r_be;
    assign dmem_wdata      = r_wdata;
    assign wb_valid        = r_wb_valid;
    assign wb_rd           = r_wb_rd;
    assign wb_data         = r_wb_data;
    assign lsu_fault       = r_fault;
    assign lsu_fault_cause = r_cause;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench for load_store_unit
// against a byte-lane arithmetic reference model.
module tb_load_store_unit;

    localparam logic [2:0] F_LB = 3'd0, F_LH = 3'd1, F_LW = 3'd2;
    localparam logic [2:0] F_LBU = 3'd4, F_LHU = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, store_data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        lsu_busy, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = 32'd0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_fault;
    logic [1:0]  lsu_fault_cause;

    int n_checks = 0;
    int n_fail = 0;

    int          o_req, o_busy, o_wb, o_wb_t;
    logic        o_stable, o_timeout, o_we;
    logic [31:0] o_addr, o_wdata, o_wbd;
    logic [3:0]  o_be;
    logic [4:0]  o_rd;
    logic        f_fault, f_req, f_busy, f_fault2, f_after;
    logic [1:0]  f_cause;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .RD_WIDTH(5)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .store_data(store_data), .rd(rd),
        .lsu_busy(lsu_busy), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .lsu_fault(lsu_fault), .lsu_fault_cause(lsu_fault_cause)
    );

    function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a, input logic [31:0] w);
        int unsigned sh;
        longint v;
        sh = 8 * (a % 4);
        case (f)
            F_LB:  begin v = (w >> sh) % 256;   if (v >= 128)   v -= 256;   end
            F_LH:  begin v = (w >> sh) % 65536; if (v >= 32768) v -= 65536; end
            F_LBU: v = (w >> sh) % 256;
            F_LHU: v = (w >> sh) % 65536;
            default: v = w;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
        if (f == 3'd0) return 4'(1 << (a % 4));
        if (f == 3'd1) return (a % 4 >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
        if (f == 3'd0) return (d % 256) * 32'h01010101;
        if (f == 3'd1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    // 0 = legal, else expected fault cause
    function automatic int m_cause(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a);
        int sz;
        if (r && w) return 3;
        if (r && (f == 3 || f == 6 || f == 7)) return 3;
        if (w && f > 2) return 3;
        sz = f % 4;
        if (sz == 1 && (a % 2) != 0) return r ? 1 : 2;
        if (sz == 2 && (a % 4) != 0) return r ? 1 : 2;
        return 0;
    endfunction

    task automatic issue(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d);
        @(negedge clk);
        ex_valid = 1'b1; mem_read = r; mem_write = w;
        funct3 = f; addr = a; store_data = sd; rd = d;
    endtask

    task automatic drop();
        ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // Runs one bus transaction: gnt withheld gd REQ cycles, rvalid withheld rvd WAIT cycles
    task automatic run_op(input logic r, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] d,
                          input int gd, input int rvd, input logic [31:0] rdat,
                          input bit inject, input bit junk);
        int rv_t;
        int ws;
        issue(r, w, f, a, sd, d);
        o_req = 0; o_busy = 0; o_wb = 0; o_wb_t = -1;
        o_stable = 1'b1; o_timeout = 1'b1; rv_t = -1; ws = 0;
        for (int t = 1; t < 100; t++) begin
            @(negedge clk);
            drop();
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
            if (inject && t == 2) begin
                ex_valid = 1'b1; mem_read = 1'b1; funct3 = F_LW;
                addr = 32'h40; rd = 5'd31;
            end
            if (lsu_busy) o_busy++;
            if (wb_valid) begin
                o_wb++; o_wb_t = t; o_wbd = wb_data; o_rd = wb_rd;
            end
            if (dmem_req) begin
                if (o_req == 0) begin
                    o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
                end else if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== {o_addr, o_be, o_wdata, o_we}) begin
                    o_stable = 1'b0;
                end
                o_req++;
                if (o_req > gd) dmem_gnt = 1'b1;
                else if (junk) dmem_rvalid = 1'b1;
            end else if (lsu_busy) begin
                ws++;
                if (ws > rvd) begin
                    dmem_rvalid = 1'b1; dmem_rdata = rdat; rv_t = t;
                end
            end
            if (rv_t >= 0 && t == rv_t + 2) begin
                o_timeout = 1'b0;
                break;
            end
        end
        drop();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    task automatic do_fault(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a);
        issue(r, w, f, a, $urandom, 5'd3);
        @(negedge clk);
        drop();
        f_fault = lsu_fault; f_cause = lsu_fault_cause;
        f_req = dmem_req; f_busy = lsu_busy;
        @(negedge clk);
        f_fault2 = lsu_fault; f_after = dmem_req | lsu_busy;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if ({lsu_busy, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_rd, wb_data, lsu_fault, lsu_fault_cause} !== '0) begin n_fail++; $display("FAIL reset_outputs got nonzero busy=%b req=%b wbv=%b fault=%b exp all 0", lsu_busy, dmem_req, wb_valid, lsu_fault); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (lsu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle busy got=%b exp=0", lsu_busy); end
    endtask

    task automatic test_lw_min_latency();
        run_op(1'b1, 1'b0, F_LW, 32'h100, 32'h0, 5'd7, 0, 0, 32'hDEADBEEF, 1'b1, 1'b0);
        n_checks++; if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL lw_timeout got=%b exp=0", o_timeout); end
        n_checks++; if ({o_addr, o_be, o_we} !== {32'h100, 4'b1111, 1'b0}) begin n_fail++; $display("FAIL lw_bus got=%h/%b/%b exp=00000100/1111/0", o_addr, o_be, o_we); end
        n_checks++; if (o_wdata !== 32'h0) begin n_fail++; $display("FAIL lw_wdata got=%h exp=0", o_wdata); end
        n_checks++; if (o_wb_t !== 3) begin n_fail++; $display("FAIL lw_wb_cycle got=%0d exp=3", o_wb_t); end
        n_checks++; if (o_wbd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data got=%h exp=deadbeef", o_wbd); end
        n_checks++; if (o_rd !== 5'd7) begin n_fail++; $display("FAIL lw_rd got=%0d exp=7", o_rd); end
        n_checks++; if (o_busy !== 2) begin n_fail++; $display("FAIL lw_busy_cycles got=%0d exp=2", o_busy); end
        n_checks++; if ({o_req, o_wb} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL lw_counts req=%0d wb=%0d exp 1/1", o_req, o_wb); end
    endtask

    task automatic test_load_ext();
        logic [2:0]  tf[3]  = '{F_LB, F_LBU, F_LH};
        logic [31:0] ta[3]  = '{32'h103, 32'h103, 32'h102};
        logic [31:0] te[3]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
        logic [2:0]  fl[5]  = '{F_LB, F_LH, F_LW, F_LBU, F_LHU};
        logic [2:0]  f;
        logic [31:0] a, w, e;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, 1'b0, tf[i], ta[i], 32'h0, 5'(i + 1), 0, 0, 32'h80FF_0000, 1'b0, 1'b0);
            n_checks++; if (o_wbd !== te[i] || o_wb !== 1) begin n_fail++; $display("FAIL ld_ext%0d got=%h wb=%0d exp=%h", i, o_wbd, o_wb, te[i]); end
        end
        for (int i = 0; i < 25; i++) begin
            f = fl[$urandom_range(0, 4)];
            a = $urandom;
            if (f % 4 == 1) a = a & ~32'h1;
            if (f % 4 == 2) a = a & ~32'h3;
            w = $urandom;
            e = m_load(f, a, w);
            run_op(1'b1, 1'b0, f, a, $urandom, 5'(i), $urandom_range(0, 3), $urandom_range(0, 3), w, 1'b0, 1'b0);
            n_checks++; if (o_wbd !== e || o_rd !== 5'(i) || o_wb !== 1 || o_timeout) begin n_fail++; $display("FAIL ld_rand f3=%0d a=%h got=%h rd=%0d exp=%h", f, a, o_wbd, o_rd, e); end
            n_checks++; if (o_addr !== (a & ~32'h3) || o_be !== 4'hF) begin n_fail++; $display("FAIL ld_rand_bus got=%h/%b exp=%h/1111", o_addr, o_be, a & ~32'h3); end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f;
        logic [31:0] a, d;
        run_op(1'b0, 1'b1, 3'd0, 32'h201, 32'h12345678, 5'd9, 0, 0, 32'h0, 1'b0, 1'b0);
        n_checks++; if ({o_be, o_wdata, o_addr, o_we} !== {4'b0010, 32'h78787878, 32'h200, 1'b1}) begin n_fail++; $display("FAIL sb_bus got be=%b wd=%h a=%h we=%b exp 0010/78787878/200/1", o_be, o_wdata, o_addr, o_we); end
        n_checks++; if (o_wb !== 0 || o_timeout) begin n_fail++; $display("FAIL sb_no_wb got wb=%0d to=%b exp 0", o_wb, o_timeout); end
        run_op(1'b0, 1'b1, 3'd1, 32'h202, 32'h12345678, 5'd9, 0, 0, 32'h0, 1'b0, 1'b0);
        n_checks++; if ({o_be, o_wdata} !== {4'b1100, 32'h56785678}) begin n_fail++; $display("FAIL sh_bus got be=%b wd=%h exp 1100/56785678", o_be, o_wdata); end
        for (int i = 0; i < 20; i++) begin
            f = 3'($urandom_range(0, 2));
            a = $urandom;
            if (f == 3'd1) a = a & ~32'h1;
            if (f == 3'd2) a = a & ~32'h3;
            d = $urandom;
            run_op(1'b0, 1'b1, f, a, d, 5'd1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0, 1'b0);
            n_checks++; if ({o_be, o_wdata, o_addr, o_we} !== {m_be(f, a), m_wdata(f, d), a & ~32'h3, 1'b1} || o_wb !== 0) begin n_fail++; $display("FAIL st_rand f3=%0d a=%h got be=%b wd=%h exp be=%b wd=%h", f, a, o_be, o_wdata, m_be(f, a), m_wdata(f, d)); end
        end
    endtask

    task automatic test_faults();
        logic        tr[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        tw[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  tf[4] = '{F_LW, 3'd1, 3'b011, F_LW};
        logic [31:0] ta[4] = '{32'h102, 32'h301, 32'h100, 32'h100};
        logic [1:0]  tc[4] = '{2'b01, 2'b10, 2'b11, 2'b11};
        logic        r, w;
        logic [2:0]  f;
        logic [31:0] a;
        int          c;
        for (int i = 0; i < 4; i++) begin
            do_fault(tr[i], tw[i], tf[i], ta[i]);
            n_checks++; if ({f_fault, f_cause} !== {1'b1, tc[i]}) begin n_fail++; $display("FAIL fault%0d got=%b/%b exp=1/%b", i, f_fault, f_cause, tc[i]); end
            n_checks++; if ({f_req, f_busy, f_fault2, f_after} !== 4'b0) begin n_fail++; $display("FAIL fault%0d_side req=%b busy=%b pulse2=%b after=%b exp 0", i, f_req, f_busy, f_fault2, f_after); end
        end
        for (int i = 0; i < 20; i++) begin
            r = 1'($urandom_range(0, 1));
            w = (r && $urandom_range(0, 3) != 0) ? 1'b0 : ~r | 1'($urandom_range(0, 1));
            f = 3'($urandom);
            a = 32'h400 + 32'($urandom_range(0, 7));
            c = m_cause(r, w, f, a);
            if (c != 0) begin
                do_fault(r, w, f, a);
                n_checks++; if ({f_fault, f_cause, f_req, f_busy, f_fault2} !== {1'b1, 2'(c), 3'b000}) begin n_fail++; $display("FAIL fault_rand r=%b w=%b f3=%0d a=%h got=%b/%b exp=1/%0d", r, w, f, a, f_fault, f_cause, c); end
            end else begin
                run_op(r, w, f, a, $urandom, 5'd2, 0, 1, $urandom, 1'b0, 1'b0);
                n_checks++; if (o_timeout || o_req !== 1 || o_wb !== (r ? 1 : 0)) begin n_fail++; $display("FAIL legal_rand r=%b f3=%0d a=%h to=%b req=%0d wb=%0d", r, f, a, o_timeout, o_req, o_wb); end
            end
        end
        issue(1'b0, 1'b0, F_LW, 32'h102, 32'h0, 5'd1);
        @(negedge clk);
        drop();
        n_checks++; if ({lsu_busy, dmem_req, lsu_fault} !== 3'b000) begin n_fail++; $display("FAIL noop_ignored got busy=%b req=%b fault=%b exp 000", lsu_busy, dmem_req, lsu_fault); end
    endtask

    task automatic test_stall();
        logic [31:0] w = 32'h7FFF1234;
        logic        seen = 1'b0;
        run_op(1'b1, 1'b0, F_LH, 32'h106, 32'h0, 5'd12, 4, 3, w, 1'b1, 1'b1);
        n_checks++; if (o_req !== 5 || o_stable !== 1'b1) begin n_fail++; $display("FAIL stall_req got req=%0d stable=%b exp 5/1", o_req, o_stable); end
        n_checks++; if (o_busy !== 9) begin n_fail++; $display("FAIL stall_busy got=%0d exp=9", o_busy); end
        n_checks++; if ({o_wb, o_wb_t} !== {32'd1, 32'd10}) begin n_fail++; $display("FAIL stall_wb got cnt=%0d t=%0d exp 1/10", o_wb, o_wb_t); end
        n_checks++; if ({o_wbd, o_rd} !== {m_load(F_LH, 32'h106, w), 5'd12}) begin n_fail++; $display("FAIL stall_data got=%h rd=%0d exp=%h rd=12", o_wbd, o_rd, m_load(F_LH, 32'h106, w)); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dmem_req || lsu_busy || wb_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL stall_inject_ignored got activity=%b exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        issue(1'b1, 1'b0, F_LW, 32'h80, 32'h0, 5'd5);
        @(negedge clk);
        drop();
        dmem_gnt = dmem_req;
        @(negedge clk);
        dmem_gnt = 1'b0;
        n_checks++; if ({lsu_busy, dmem_req} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_wait got busy=%b req=%b exp 1/0", lsu_busy, dmem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({lsu_busy, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, wb_valid, wb_rd, wb_data, lsu_fault, lsu_fault_cause} !== '0) begin n_fail++; $display("FAIL rst_mid_outputs got busy=%b addr=%h wbd=%h exp all 0", lsu_busy, dmem_addr, wb_data); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 1'b1, F_LW, 32'h300, 32'hAABBCCDD, 5'd4, 1, 0, 32'h0, 1'b0, 1'b0);
        n_checks++; if ({o_addr, o_be, o_wdata, o_we} !== {32'h300, 4'hF, 32'hAABBCCDD, 1'b1} || o_busy !== 3 || o_wb !== 0) begin n_fail++; $display("FAIL rst_sw got a=%h be=%b wd=%h busy=%0d wb=%0d", o_addr, o_be, o_wdata, o_busy, o_wb); end
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55AA55AA;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        n_checks++; if ({lsu_busy, dmem_req, wb_valid} !== 3'b000) begin n_fail++; $display("FAIL late_rvalid got busy=%b req=%b wbv=%b exp 000", lsu_busy, dmem_req, wb_valid); end
    endtask

    initial begin
        test_reset();
        test_lw_min_latency();
        test_load_ext();
        test_store();
        test_faults();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
